// File: rtl/muldiv_if.sv
// muldiv_if: request and writeback bundle for muldiv_unit.
//   master : issuing stage (drives valid_in/funct3/op_a/op_b/rd_in,
//            observes ready_in/busy and the writeback port)
//   slave  : muldiv_unit
//   valid_in/ready_in : request handshake, accept when both high
//   funct3            : RV32M operation select
//   op_a/op_b         : rs1/rs2 values
//   rd_in             : destination register
//   busy              : unit is not idle
//   wb_we/wb_rd/wb_wd : one-cycle writeback to the register file
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            ready_in;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_wd;

    modport master (
        output valid_in, funct3, op_a, op_b, rd_in,
        input  ready_in, busy, wb_we, wb_rd, wb_wd
    );

    modport slave (
        input  valid_in, funct3, op_a, op_b, rd_in,
        output ready_in, busy, wb_we, wb_rd, wb_wd
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit. One operation at a
// time; 32 shift-add or restoring-divide iterations on operand magnitudes,
// then a sign/special-case fixup, then a one-cycle writeback pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : muldiv_if.slave (request handshake, operands, writeback)
// Build option: MULDIV_EARLY_OUT_EN - divide-by-zero, signed overflow and
//   zero operands go straight to DONE on accept (1-cycle latency).
//
// state | meaning
// IDLE  | waiting for a request, ready_in high
// CALC  | 32 iterations, count 0..31
// FIX   | apply signs / special cases, load writeback data
// DONE  | wb_we pulse (unless rd==0)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic [4:0]      count;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            sign_a, sign_b, div_zero, div_ovf;
    logic [XLEN-1:0] a_raw, opnd, acc_hi, acc_lo;

    logic            accept;
    logic            sgn_a_in, sgn_b_in, dz_in, ovf_in;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            early_go;
    logic [XLEN-1:0] early_res;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, res;

    assign accept   = bus.valid_in && bus.ready_in;
    assign sgn_a_in = bus.op_a[XLEN-1] && (bus.funct3 == F_MULH || bus.funct3 == F_MULHSU ||
                                           bus.funct3 == F_DIV  || bus.funct3 == F_REM);
    assign sgn_b_in = bus.op_b[XLEN-1] && (bus.funct3 == F_MULH || bus.funct3 == F_DIV ||
                                           bus.funct3 == F_REM);
    assign abs_a    = sgn_a_in ? -bus.op_a : bus.op_a;
    assign abs_b    = sgn_b_in ? -bus.op_b : bus.op_b;
    assign dz_in    = bus.funct3[2] && (bus.op_b == '0);
    assign ovf_in   = (bus.funct3 == F_DIV || bus.funct3 == F_REM) &&
                      (bus.op_a == INT_MIN) && (bus.op_b == ALL_ONES);

`ifdef MULDIV_EARLY_OUT_EN
    // A zero operand gives 0 for every op except the divide-by-zero cases,
    // which take priority.
    assign early_go = dz_in || ovf_in || (bus.op_a == '0) || (bus.op_b == '0);
    always_comb begin
        early_res = '0;
        if (dz_in)
            early_res = bus.funct3[1] ? bus.op_a : ALL_ONES;
        else if (ovf_in)
            early_res = bus.funct3[1] ? '0 : INT_MIN;
    end
`else
    assign early_go  = 1'b0;
    assign early_res = '0;
`endif

    // Shift-add: low half starts as the multiplier and shifts out as the
    // product's low half shifts in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    // Restoring divide: the partial remainder is always below the divisor,
    // so a 32-bit difference is exact whenever the subtraction is taken.
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[XLEN-1:0] - opnd;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    assign quo_fix  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
    assign rem_fix  = sign_a ? -acc_hi : acc_hi;

    always_comb begin
        res = '0;
        case (f3_q)
            F_MUL:                      res = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  res = prod_fix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              res = div_zero ? ALL_ONES : (div_ovf ? INT_MIN : quo_fix);
            F_REM, F_REMU:              res = div_zero ? a_raw : (div_ovf ? '0 : rem_fix);
            default:                    res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = early_go ? DONE : CALC;
            CALC: if (count == 5'd31) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state != IDLE);
        bus.ready_in = (state == IDLE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            div_zero   <= 1'b0;
            div_ovf    <= 1'b0;
            a_raw      <= '0;
            opnd       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            bus.wb_we  <= 1'b0;
            bus.wb_rd  <= '0;
            bus.wb_wd  <= '0;
        end else begin
            bus.wb_we <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    f3_q     <= bus.funct3;
                    rd_q     <= bus.rd_in;
                    sign_a   <= sgn_a_in;
                    sign_b   <= sgn_b_in;
                    div_zero <= dz_in;
                    div_ovf  <= ovf_in;
                    a_raw    <= bus.op_a;
                    count    <= '0;
                    acc_hi   <= '0;
                    if (bus.funct3[2]) begin
                        acc_lo <= abs_a;
                        opnd   <= abs_b;
                    end else begin
                        acc_lo <= abs_b;
                        opnd   <= abs_a;
                    end
                    if (early_go) begin
                        bus.wb_we <= (bus.rd_in != '0);
                        bus.wb_rd <= bus.rd_in;
                        bus.wb_wd <= early_res;
                    end
                end
                CALC: begin
                    count <= count + 5'd1;
                    if (f3_q[2]) begin
                        acc_hi <= div_ge ? div_sub : div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    bus.wb_we <= (rd_q != '0);
                    bus.wb_rd <= rd_q;
                    bus.wb_wd <= res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    muldiv_if bus();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op and watch 40 cycles: latency, data, rd, single pulse,
    // ready_in return. special marks ops eligible for early out.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_wd,
                          input bit special, input bit poke);
        int lat, n_we, seen_at;
        logic [31:0] got_wd;
        logic [4:0]  got_rd;
        lat = (special && EO) ? 1 : 34;
        n_we = 0; seen_at = 0; got_wd = '0; got_rd = '0;
        @(negedge clk);
        for (int i = 0; i < 50 && !bus.ready_in; i++) @(negedge clk);
        check_val({tag, " ready_before"}, {31'd0, bus.ready_in}, 32'd1);
        bus.valid_in = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0; bus.op_a = ~a; bus.op_b = ~b; bus.funct3 = ~f3; bus.rd_in = ~rd;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (poke && n == 5) begin
                bus.valid_in = 1'b1; bus.funct3 = 3'b000;
                bus.op_a = 32'd9; bus.op_b = 32'd9; bus.rd_in = 5'd7;
            end else if (poke && n == 6) begin
                bus.valid_in = 1'b0;
            end
            if (bus.wb_we) begin
                n_we++;
                if (seen_at == 0) begin
                    seen_at = n; got_wd = bus.wb_wd; got_rd = bus.wb_rd;
                end
            end
            if (n == 1) check_val({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            if (n == lat) check_val({tag, " ready_during_done"}, {31'd0, bus.ready_in}, 32'd0);
            if (n == lat + 1) check_val({tag, " ready_after"}, {31'd0, bus.ready_in}, 32'd1);
        end
        check_val({tag, " we_count"}, n_we, (rd != 5'd0) ? 32'd1 : 32'd0);
        if (rd != 5'd0) begin
            check_val({tag, " latency"}, seen_at, lat);
            check_val({tag, " wb_wd"}, got_wd, exp_wd);
            check_val({tag, " wb_rd"}, {27'd0, got_rd}, {27'd0, rd});
        end
    endtask

    initial begin
        int n_we;
        bus.valid_in = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst ready", {31'd0, bus.ready_in}, 32'd0);
        check_val("rst busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst wb_we", {31'd0, bus.wb_we}, 32'd0);
        check_val("rst wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        check_val("rst wb_wd", bus.wb_wd, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst ready", {31'd0, bus.ready_in}, 32'd1);

        run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        5'd3,  32'd42,       1'b0, 1'b0);
        run_op("mul_neg",     3'b000, 32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFF1, 1'b0, 1'b0);
        run_op("mulh_min",    3'b001, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 1'b0, 1'b0);
        run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("mulhsu",      3'b010, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       1'b0, 1'b0);
        run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        5'd11, 32'd2,        1'b0, 1'b0);
        run_op("div_by0",     3'b100, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("rem_by0",     3'b110, 32'd5,        32'd0,        5'd13, 32'd5,        1'b1, 1'b0);
        run_op("rem_by0_neg", 3'b110, 32'hFFFFFFF0, 32'd0,        5'd14, 32'hFFFFFFF0, 1'b1, 1'b0);
        run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1, 1'b0);
        run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1'b1, 1'b0);
        run_op("mul_zero",    3'b000, 32'd0,        32'd5,        5'd17, 32'd0,        1'b1, 1'b0);
        run_op("divu_rd0",    3'b101, 32'd10,       32'd2,        5'd0,  32'd5,        1'b0, 1'b0);
        run_op("busy_poke",   3'b000, 32'd11,       32'd3,        5'd18, 32'd33,       1'b0, 1'b1);

        // Reset mid-operation: accept at E, rst high over edge E+10.
        @(negedge clk);
        bus.valid_in = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd5;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst ready_in_rst", {31'd0, bus.ready_in}, 32'd0);
        check_val("midrst busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst ready_after", {31'd0, bus.ready_in}, 32'd1);
        n_we = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wb_we) n_we++;
        end
        check_val("midrst no_we", n_we, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
